// File: rtl/alu_share_ctrl_if.sv
// Bundle of the requester, ALU and response signals around alu_share_ctrl.
// The slave modport is the controller's view; master is the environment's view.
interface alu_share_ctrl_if #(
    parameter int N = 32
);
    logic         req0_valid;
    logic         req0_ready;
    logic [N-1:0] req0_a;
    logic [N-1:0] req0_b;
    logic [2:0]   req0_op;

    logic         req1_valid;
    logic         req1_ready;
    logic [N-1:0] req1_a;
    logic [N-1:0] req1_b;
    logic [2:0]   req1_op;

    logic [N-1:0] alu_a;
    logic [N-1:0] alu_b;
    logic [2:0]   alu_op;
    logic [N-1:0] alu_z;
    logic         alu_ex;

    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic [N-1:0] rsp_z;
    logic         rsp_ex;
    logic         rsp_err;
    logic         busy;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_z, alu_ex,
        output rsp_valid, rsp_id, rsp_z, rsp_ex, rsp_err, busy,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_z, alu_ex,
        input  rsp_valid, rsp_id, rsp_z, rsp_ex, rsp_err, busy,
        output rsp_ready
    );
endinterface

// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters, one op in flight.
//
// state | meaning
// IDLE  | arbitrate between valid requesters, accept one op
// EXEC  | registered operands drive the ALU, result captured at edge
// RESP  | response held on rsp_* until the consumer takes it
module alu_share_ctrl #(
    parameter int N = 32
) (
    input  logic              clk,
    input  logic              reset,
    alu_share_ctrl_if.slave   bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t       state;
    state_t       state_nxt;
    logic         rr;
    logic         grant;
    logic         acc0;
    logic         acc1;
    logic         accept;
    logic [N-1:0] opa_q;
    logic [N-1:0] opb_q;
    logic [2:0]   op_q;
    logic         id_q;
    logic [N-1:0] z_q;
    logic         ex_q;
    logic         err_q;

    function automatic logic op_legal(input logic [2:0] op);
        case (op)
            3'b000, 3'b001, 3'b010, 3'b110, 3'b111: op_legal = 1'b1;
            default:                                op_legal = 1'b0;
        endcase
    endfunction

    // Arbitration: a lone requester wins; on contention rr names the winner.
    always_comb begin
        grant = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = rr;
        end else if (bus.req1_valid) begin
            grant = 1'b1;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        state_nxt = state;
        acc0      = 1'b0;
        acc1      = 1'b0;
        case (state)
            IDLE: begin
                acc0 = bus.req0_valid && !grant;
                acc1 = bus.req1_valid && grant;
                if (acc0 || acc1) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: state_nxt = RESP;
            RESP: begin
                if (bus.rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept = acc0 | acc1;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand capture on accept, result capture at the end of EXEC.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr    <= 1'b0;
            opa_q <= '0;
            opb_q <= '0;
            op_q  <= 3'b000;
            id_q  <= 1'b0;
            z_q   <= '0;
            ex_q  <= 1'b0;
            err_q <= 1'b0;
        end else begin
            if (accept) begin
                opa_q <= grant ? bus.req1_a  : bus.req0_a;
                opb_q <= grant ? bus.req1_b  : bus.req0_b;
                op_q  <= grant ? bus.req1_op : bus.req0_op;
                id_q  <= grant;
                rr    <= ~grant;
                err_q <= 1'b0;
            end
            if (state == EXEC) begin
                if (op_legal(op_q)) begin
                    z_q   <= bus.alu_z;
                    ex_q  <= bus.alu_ex;
                    err_q <= 1'b0;
                end else begin
                    z_q   <= '0;
                    ex_q  <= 1'b0;
                    err_q <= 1'b1;
                end
            end
        end
    end

    assign bus.req0_ready = acc0;
    assign bus.req1_ready = acc1;
    assign bus.alu_a      = opa_q;
    assign bus.alu_b      = opb_q;
    assign bus.alu_op     = op_q;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_z      = z_q;
    assign bus.rsp_ex     = ex_q;
    assign bus.rsp_err    = err_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Bench for alu_share_ctrl: directed scenarios plus random traffic, all
// checked cycle by cycle against a transaction-level reference model.
module tb_alu_share_ctrl;
    localparam int N = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_share_ctrl_if #(.N(N)) bus ();

    alu_share_ctrl #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Stand-in for yAlu; unsupported codes produce junk the controller must mask.
    always_comb begin
        case (bus.alu_op)
            3'b000:  bus.alu_z = bus.alu_a & bus.alu_b;
            3'b001:  bus.alu_z = bus.alu_a | bus.alu_b;
            3'b010:  bus.alu_z = bus.alu_a + bus.alu_b;
            3'b110:  bus.alu_z = bus.alu_a - bus.alu_b;
            3'b111:  bus.alu_z = ($signed(bus.alu_a) < $signed(bus.alu_b)) ? 32'd1 : 32'd0;
            default: bus.alu_z = bus.alu_a ^ bus.alu_b ^ 32'h5A5A_A5A5;
        endcase
        bus.alu_ex = (bus.alu_z == 32'd0);
    end

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected result of one operation, straight from the op table.
    task automatic ref_alu(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                           output logic [31:0] z, output logic ex, output logic err);
        longint sa, sb;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        err = 1'b0;
        case (op)
            3'b000:  z = a & b;
            3'b001:  z = a | b;
            3'b010:  z = 32'(sa + sb);
            3'b110:  z = 32'(sa - sb);
            3'b111:  z = (sa < sb) ? 32'd1 : 32'd0;
            default: begin z = 32'd0; err = 1'b1; end
        endcase
        ex = err ? 1'b0 : (z == 32'd0);
    endtask

    // Reference model: phase 0 idle, 1 executing, 2 response pending.
    int          m_phase = 0;
    bit          m_pref  = 1'b0;
    logic [31:0] m_a = '0, m_b = '0, m_z = '0;
    logic [2:0]  m_op = '0;
    logic        m_id = 1'b0, m_ex = 1'b0, m_err = 1'b0;

    task automatic model_reset();
        m_phase = 0; m_pref = 1'b0;
        m_a = '0; m_b = '0; m_op = '0; m_id = 1'b0;
        m_z = '0; m_ex = 1'b0; m_err = 1'b0;
    endtask

    // One clock: check outputs at the negedge, advance the model, return just after posedge.
    task automatic step();
        int win;
        @(negedge clk);
        win = -1;
        if (m_phase == 0) begin
            if (bus.req0_valid && bus.req1_valid) win = int'(m_pref);
            else if (bus.req0_valid)              win = 0;
            else if (bus.req1_valid)              win = 1;
        end
        if (!reset) begin
            chk("req0_ready", bus.req0_ready, (win == 0));
            chk("req1_ready", bus.req1_ready, (win == 1));
        end
        chk("busy",      bus.busy,      (m_phase != 0));
        chk("rsp_valid", bus.rsp_valid, (m_phase == 2));
        chk("alu_a",     bus.alu_a,     m_a);
        chk("alu_b",     bus.alu_b,     m_b);
        chk("alu_op",    bus.alu_op,    m_op);
        chk("rsp_id",    bus.rsp_id,    m_id);
        chk("rsp_z",     bus.rsp_z,     m_z);
        chk("rsp_ex",    bus.rsp_ex,    m_ex);
        chk("rsp_err",   bus.rsp_err,   m_err);
        if (reset) begin
            model_reset();
        end else if (m_phase == 0) begin
            if (win == 0) begin
                m_a = bus.req0_a; m_b = bus.req0_b; m_op = bus.req0_op;
            end else if (win == 1) begin
                m_a = bus.req1_a; m_b = bus.req1_b; m_op = bus.req1_op;
            end
            if (win >= 0) begin
                m_id = (win == 1); m_pref = (win == 0); m_err = 1'b0; m_phase = 1;
            end
        end else if (m_phase == 1) begin
            ref_alu(m_a, m_b, m_op, m_z, m_ex, m_err);
            m_phase = 2;
        end else if (bus.rsp_ready) begin
            m_phase = 0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_rsp(input string tag, input logic [31:0] exp_z,
                            input logic exp_id, input logic exp_err);
        int k;
        k = 0;
        step();
        while (!bus.rsp_valid && k < 10) begin
            step();
            k++;
        end
        chk({tag, "_valid"}, bus.rsp_valid, 1'b1);
        chk({tag, "_z"},     bus.rsp_z,     exp_z);
        chk({tag, "_id"},    bus.rsp_id,    exp_id);
        chk({tag, "_err"},   bus.rsp_err,   exp_err);
    endtask

    task automatic set_req0(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bus.req0_valid = v; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
    endtask

    task automatic set_req1(input logic v, input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
        bus.req1_valid = v; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
    endtask

    initial begin
        reset = 1'b1;
        bus.rsp_ready = 1'b1;
        set_req0(1'b1, 32'd5, 32'd3, 3'b010);
        set_req1(1'b0, 32'd0, 32'd0, 3'b000);
        @(posedge clk);
        #1;
        step();
        reset = 1'b0;

        // Reset release and single ADD.
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_busy",      bus.busy,      1'b0);
        chk("rst_req0_ready", bus.req0_ready, 1'b1);
        step();
        bus.req0_valid = 1'b0;
        chk("add_busy_t1", bus.busy, 1'b1);
        step();
        chk("add_busy_t2", bus.busy, 1'b1);
        chk("add_valid",   bus.rsp_valid, 1'b1);
        chk("add_z",       bus.rsp_z, 32'd8);
        chk("add_id",      bus.rsp_id, 1'b0);
        chk("add_err",     bus.rsp_err, 1'b0);
        step();

        // Contention from reset: req0, then req1, then req0 again.
        reset = 1'b1;
        step();
        reset = 1'b0;
        set_req0(1'b1, 32'd12, 32'd10, 3'b000);
        set_req1(1'b1, 32'd3, 32'd5, 3'b110);
        wait_rsp("cont0", 32'd8, 1'b0, 1'b0);
        set_req0(1'b1, 32'd1, 32'd1, 3'b010);
        wait_rsp("cont1", 32'hFFFF_FFFE, 1'b1, 1'b0);
        bus.req1_valid = 1'b0;
        wait_rsp("cont2", 32'd2, 1'b0, 1'b0);
        bus.req0_valid = 1'b0;
        repeat (3) step();

        // SLT under backpressure, with req0 knocking throughout.
        bus.rsp_ready = 1'b0;
        set_req1(1'b1, 32'hFFFF_FFFF, 32'd1, 3'b111);
        wait_rsp("slt", 32'd1, 1'b1, 1'b0);
        bus.req1_valid = 1'b0;
        set_req0(1'b1, 32'd6, 32'd6, 3'b001);
        for (int i = 0; i < 4; i++) begin
            chk("bp_z",      bus.rsp_z, 32'd1);
            chk("bp_valid",  bus.rsp_valid, 1'b1);
            chk("bp_ready0", bus.req0_ready, 1'b0);
            step();
        end
        bus.req0_valid = 1'b0;
        bus.rsp_ready  = 1'b1;
        step();
        chk("bp_release_busy", bus.busy, 1'b0);

        // Unsupported op, then a legal one clears the error.
        set_req0(1'b1, 32'd7, 32'd9, 3'b011);
        wait_rsp("unsup", 32'd0, 1'b0, 1'b1);
        chk("unsup_ex", bus.rsp_ex, 1'b0);
        set_req0(1'b1, 32'd4, 32'd1, 3'b001);
        wait_rsp("after_unsup", 32'd5, 1'b0, 1'b0);
        bus.req0_valid = 1'b0;
        repeat (2) step();

        // Reset while executing discards the op.
        set_req0(1'b1, 32'd100, 32'd1, 3'b010);
        step();
        bus.req0_valid = 1'b0;
        chk("rexec_busy", bus.busy, 1'b1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("rexec_cleared", bus.busy, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk("rexec_no_rsp", bus.rsp_valid, 1'b0);
            step();
        end
        set_req1(1'b1, 32'd2, 32'd2, 3'b010);
        wait_rsp("rexec_next", 32'd4, 1'b1, 1'b0);
        bus.req1_valid = 1'b0;
        step();

        // Random traffic.
        for (int c = 0; c < 1500; c++) begin
            reset          = ($urandom_range(0, 199) == 0);
            bus.rsp_ready  = ($urandom_range(0, 3) != 0);
            bus.req0_valid = ($urandom_range(0, 2) != 0);
            bus.req1_valid = ($urandom_range(0, 2) != 0);
            bus.req0_a     = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
            bus.req0_b     = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 15));
            bus.req1_a     = $urandom;
            bus.req1_b     = ($urandom_range(0, 3) == 0) ? bus.req1_a : $urandom;
            bus.req0_op    = 3'($urandom_range(0, 7));
            bus.req1_op    = 3'($urandom_range(0, 7));
            step();
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_share_ctrl.md
# alu_share_ctrl

Sequencer and arbiter that shares one combinational `yAlu` instance between two requesters. Each request (a, b, op) is accepted through a valid/ready handshake and driven onto the ALU from registered operands. The result (z, ex) is captured and returned on a single tagged response channel. The block sits between the lab's ALU datapath and its clients (test sequencers, future multi-cycle CPU control), and only ever has one operation in flight.

## Interface
Parameters:
- `N`, 32, operand/result width (matches `yAlu`)

Ports:
- `clk`  in  1  system clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `req0_valid`  in  1  requester 0 has an operation
- `req0_ready`  out  1  requester 0 accepted this cycle
- `req0_a`, `req0_b`  in  N  operands, signed
- `req0_op`  in  3  ALU op code
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as requester 0, for requester 1
- `alu_a`, `alu_b`  out  N  to `yAlu` inputs, driven from registers
- `alu_op`  out  3  to `yAlu` op, from register
- `alu_z`  in  N  from `yAlu` result
- `alu_ex`  in  1  from `yAlu` ex flag
- `rsp_valid`  out  1  response available
- `rsp_ready`  in  1  consumer takes response
- `rsp_id`  out  1  requester that issued the response
- `rsp_z`  out  N  captured result
- `rsp_ex`  out  1  captured ex flag
- `rsp_err`  out  1  op code was unsupported
- `busy`  out  1  state != IDLE

## Operation
- Legal ops: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT (signed). Ops 011, 100 and 101 are unsupported.
- FSM has three states: IDLE, EXEC, RESP.
- **IDLE:**
  - Arbiter picks `grant` from the valid requesters.
  - If only one requester is valid, it is granted.
  - If both are valid, the round-robin pointer `rr` decides.
  - `reqX_ready = (state==IDLE) && reqX_valid && grant==X`. It is combinational, and at most one ready is high.
  - On a handshake:
    - latch a, b and op into the operand registers;
    - latch the id;
    - set `rr` to the other requester;
    - go to EXEC.
- **EXEC:** the registered operands drive the ALU. At the clock edge:
  - `rsp_z <= alu_z` and `rsp_ex <= alu_ex` for legal ops;
  - for unsupported ops: `rsp_z <= 0`, `rsp_ex <= 0`, `rsp_err <= 1`;
  - go to RESP.
- **RESP:** `rsp_valid=1`, with all `rsp_*` held stable.
  - If `rsp_ready=1`, go to IDLE.
  - Otherwise stay in RESP indefinitely (backpressure).
- The operand registers hold their value outside IDLE-accept. The ALU outputs keep showing the last operation.
- `rr` changes only on an accepted handshake, never on idle cycles.

## Timing
- **Reset values:**
  - state=IDLE, `rr`=0 (requester 0 preferred);
  - `alu_a`=0, `alu_b`=0, `alu_op`=000;
  - `rsp_valid`=0, `rsp_id`=0, `rsp_z`=0, `rsp_ex`=0, `rsp_err`=0, `busy`=0.
- **Latency:** handshake at edge T → EXEC during cycle T+1 → `rsp_valid` high in cycle T+2.
- **Throughput:** one op per 3 cycles, with `rsp_ready` held high.
  - With `rsp_ready=1` in the first RESP cycle, the next accept can occur in the following cycle (IDLE).
  - There is no IDLE bypass.
- **Backpressure:** both `reqX_ready` stay 0 for the whole time spent outside IDLE.
- **Simultaneous valids after the previous grant:** the other requester wins. This gives strict alternation under continuous load.
- **Requester drops valid:** if it drops valid in IDLE before the handshake, no accept occurs. A requester may change a, b or op freely while not handshaking.
- **Reset mid-operation (EXEC or RESP):**
  - the in-flight op is discarded;
  - no response is issued;
  - all outputs return to their reset values the next cycle.
- **`rsp_err`:** cleared when the next op is accepted (on the IDLE→EXEC edge).

## Test plan
- **Reset:** assert `reset` for 2 cycles with `req0_valid=1`.
  - During reset: `req0_ready` is don't-care.
  - After release: all `rsp_*` are 0, `busy`=0, and `req0_ready`=1 in the first IDLE cycle.
- **Single ADD:** req0 a=5, b=3, op=010, handshake at cycle T.
  - `rsp_valid`=1 at T+2 with `rsp_z`=8, `rsp_id`=0, `rsp_err`=0.
  - `busy`=1 during T+1 and T+2.
- **Contention:** both requesters valid from reset.
  - req0 (a=12, b=10, op=000) is granted first, giving `rsp_z`=8, `rsp_id`=0.
  - req1 (a=3, b=5, op=110) follows, giving `rsp_z`=0xFFFFFFFE, `rsp_id`=1.
  - A third request from req0 is granted only after req1.
- **SLT and backpressure:** req1 a=-1, b=1, op=111 with `rsp_ready`=0 for 4 cycles.
  - `rsp_z`=1 is held stable for all 4 cycles, with both readys at 0.
  - Raising `rsp_ready` returns the block to IDLE the next cycle.
- **Unsupported op:** req0 op=011, a=7, b=9.
  - Response has `rsp_err`=1, `rsp_z`=0, `rsp_ex`=0.
  - A following legal op (op=001, a=4, b=1) returns `rsp_err`=0, `rsp_z`=5.
- **Reset during EXEC:** accept req0, then assert `reset` in the EXEC cycle.
  - No `rsp_valid` is seen.
  - The next req1 request (a=2, b=2, op=010) is granted with `rr` back at 0 and completes with `rsp_z`=4.
